// File: rtl/ovl_delta_pkg.sv
// Shared types and arithmetic helpers for the multi-channel delta checker.
// Helpers take 32-bit operands so one definition serves any WIDTH up to 31.
package ovl_delta_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } ch_state_e;

  localparam int unsigned ARG_W = 32;

  function automatic logic [ARG_W:0] delta_calc(
    input logic [ARG_W-1:0] value,
    input logic [ARG_W-1:0] prev,
    input int unsigned      width,
    input logic             wrap
  );
    logic [ARG_W:0] v;
    logic [ARG_W:0] p;
    logic [ARG_W:0] modulus;
    logic [ARG_W:0] d;
    v = {1'b0, value};
    p = {1'b0, prev};
    modulus = {{ARG_W{1'b0}}, 1'b1} << width;
    if (wrap) begin
      d = (v - p) & (modulus - 1'b1);
      if ((modulus - d) < d) d = modulus - d;
    end else begin
      d = (v >= p) ? (v - p) : (p - v);
    end
    return d;
  endfunction

  function automatic logic [ARG_W-1:0] sat_add(
    input logic [ARG_W-1:0] a,
    input logic [ARG_W-1:0] b,
    input int unsigned      width
  );
    logic [ARG_W:0] s;
    logic [ARG_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ({{ARG_W{1'b0}}, 1'b1} << width) - 1'b1;
    return (s > lim) ? lim[ARG_W-1:0] : s[ARG_W-1:0];
  endfunction

endpackage

// File: rtl/ovl_delta_mc_if.sv
// Monitor bundle: sampled stimulus in, checker status out.
interface ovl_delta_mc_if #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8,
  parameter int FCW       = 2
);
  logic                      enable;
  logic [NUM_CH*WIDTH-1:0]   test_expr;
  logic                      clear;
  logic [NUM_CH-1:0]         fire;
  logic                      fire_any;
  logic                      sticky_err;
  logic [CNT_WIDTH-1:0]      err_count;
  logic [FCW-1:0]            first_ch;
  logic [CNT_WIDTH-1:0]      cov_changes;

  modport master (
    output enable, test_expr, clear,
    input  fire, fire_any, sticky_err,
    input  err_count, first_ch, cov_changes
  );

  modport slave (
    input  enable, test_expr, clear,
    output fire, fire_any, sticky_err,
    output err_count, first_ch, cov_changes
  );
endinterface

// File: rtl/ovl_delta_ch.sv
// One delta-checker channel: IDLE/ARMED tracking, prev register,
// combinational violation and legal-change flags for the current sample.
module ovl_delta_ch
  import ovl_delta_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MIN       = 2,
  parameter int MAX       = 4,
  parameter int WRAP_MODE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic             viol,
  output logic             legal
);

  ch_state_e        state;
  logic [WIDTH-1:0] prev;
  logic [ARG_W:0]   delta;
  logic             check;
  logic             nz;
  logic             oob;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      prev  <= '0;
    end else if (enable) begin
      state <= ARMED;
      prev  <= value;
    end else begin
      state <= IDLE;
    end
  end

  assign check = enable && (state == ARMED);
  assign delta = delta_calc(ARG_W'(value), ARG_W'(prev),
                            WIDTH, WRAP_MODE != 0);
  assign nz    = delta != '0;
  assign oob   = (delta < (ARG_W+1)'(MIN)) ||
                 (delta > (ARG_W+1)'(MAX));
  assign viol  = check && nz && oob;
  assign legal = check && nz && !oob;

endmodule

// File: rtl/ovl_delta_mc.sv
// Multi-channel delta checker top: fire flags, counters, first-fail capture.
// Define OVL_DELTA_COVER_EN to build the legal-change coverage counter.
module ovl_delta_mc
  import ovl_delta_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 4,
  parameter int MIN       = 2,
  parameter int MAX       = 4,
  parameter int WRAP_MODE = 0,
  parameter int CNT_WIDTH = 8
) (
  input logic           clock,
  input logic           reset,
  ovl_delta_mc_if.slave mon
);

  localparam int FCW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (MIN < 1 || MIN > MAX || WIDTH < 1 || WIDTH > 31 ||
      64'(MAX) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_param
    $error("ovl_delta_mc: illegal MIN/MAX/WIDTH combination");
  end

  logic [NUM_CH-1:0] viol;
  logic [NUM_CH-1:0] legal;
  logic [FCW-1:0]    low;
  logic [ARG_W-1:0]  nviol;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ovl_delta_ch #(
      .WIDTH     (WIDTH),
      .MIN       (MIN),
      .MAX       (MAX),
      .WRAP_MODE (WRAP_MODE)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .enable (mon.enable),
      .value  (mon.test_expr[i*WIDTH +: WIDTH]),
      .viol   (viol[i]),
      .legal  (legal[i])
    );
  end

  // Scan downward so the lowest failing index is the one left standing.
  always_comb begin
    low = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (viol[i]) low = FCW'(i);
    end
  end

  assign nviol = ARG_W'($countones(viol));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mon.fire       <= '0;
      mon.fire_any   <= 1'b0;
      mon.sticky_err <= 1'b0;
      mon.err_count  <= '0;
      mon.first_ch   <= '0;
    end else begin
      mon.fire     <= viol;
      mon.fire_any <= |viol;
      if (mon.clear) begin
        mon.sticky_err <= 1'b0;
        mon.err_count  <= '0;
        mon.first_ch   <= '0;
      end else if (|viol) begin
        mon.sticky_err <= 1'b1;
        mon.err_count  <= CNT_WIDTH'(sat_add(ARG_W'(mon.err_count),
                                             nviol, CNT_WIDTH));
        if (!mon.sticky_err) mon.first_ch <= low;
      end
    end
  end

`ifdef OVL_DELTA_COVER_EN
  logic [ARG_W-1:0] nlegal;
  assign nlegal = ARG_W'($countones(legal));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mon.cov_changes <= '0;
    end else if (mon.clear) begin
      mon.cov_changes <= '0;
    end else begin
      mon.cov_changes <= CNT_WIDTH'(sat_add(ARG_W'(mon.cov_changes),
                                            nlegal, CNT_WIDTH));
    end
  end
`else
  logic cov_unused;
  assign cov_unused      = ^legal;
  assign mon.cov_changes = '0;
`endif

endmodule

// File: tb/tb_ovl_delta_mc.sv
// Directed bench for ovl_delta_mc: default, wrap-mode and 2-bit-counter
// instances share one stimulus stream.
module tb_ovl_delta_mc;

`ifdef OVL_DELTA_COVER_EN
  localparam bit COV = 1'b1;
`else
  localparam bit COV = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b0;
  logic        clr   = 1'b0;
  logic [15:0] tx    = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  ovl_delta_mc_if #(.NUM_CH(4), .WIDTH(4), .CNT_WIDTH(8), .FCW(2)) m_if ();
  ovl_delta_mc_if #(.NUM_CH(4), .WIDTH(4), .CNT_WIDTH(8), .FCW(2)) w_if ();
  ovl_delta_mc_if #(.NUM_CH(4), .WIDTH(4), .CNT_WIDTH(2), .FCW(2)) s_if ();

  assign m_if.enable = en;
  assign m_if.test_expr = tx;
  assign m_if.clear = clr;
  assign w_if.enable = en;
  assign w_if.test_expr = tx;
  assign w_if.clear = clr;
  assign s_if.enable = en;
  assign s_if.test_expr = tx;
  assign s_if.clear = clr;

  ovl_delta_mc #(.NUM_CH(4), .WIDTH(4), .MIN(2), .MAX(4),
                 .WRAP_MODE(0), .CNT_WIDTH(8))
    u_main (.clock(clock), .reset(reset), .mon(m_if.slave));
  ovl_delta_mc #(.NUM_CH(4), .WIDTH(4), .MIN(2), .MAX(4),
                 .WRAP_MODE(1), .CNT_WIDTH(8))
    u_wrap (.clock(clock), .reset(reset), .mon(w_if.slave));
  ovl_delta_mc #(.NUM_CH(4), .WIDTH(4), .MIN(2), .MAX(4),
                 .WRAP_MODE(0), .CNT_WIDTH(2))
    u_sat (.clock(clock), .reset(reset), .mon(s_if.slave));

  task automatic drive(input logic e, input logic [15:0] v,
                       input logic c);
    en = e; tx = v; clr = c;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; en = 1'b0; clr = 1'b0; tx = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1, 16'h0001, 0);
    drive(1, 16'h0002, 0);
    drive(1, 16'h0000, 0);
    n_chk++;
    if (m_if.fire !== 4'b0 || m_if.fire_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fire got %b/%b want 0000/0", m_if.fire, m_if.fire_any);
    end
    n_chk++;
    if (m_if.err_count !== 8'd0 || m_if.sticky_err !== 1'b0 ||
        m_if.first_ch !== 2'd0 || m_if.cov_changes !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state got cnt=%0d st=%b fc=%0d cov=%0d want 0",
               m_if.err_count, m_if.sticky_err, m_if.first_ch, m_if.cov_changes);
    end
    reset = 1'b1;
    drive(1, 16'h0001, 0);
    n_chk++;
    if (m_if.fire !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_prime got %b want 0000", m_if.fire);
    end
  endtask

  task automatic test_single();
    logic [15:0] seq [6] = '{16'h1, 16'h2, 16'h3, 16'h9, 16'h9, 16'hB};
    logic        exp [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, seq[i], 0);
      n_chk++;
      if (m_if.fire !== {3'b0, exp[i]} || m_if.fire_any !== exp[i]) begin
        n_fail++;
        $display("FAIL single_fire[%0d] got %b/%b want %b", i,
                 m_if.fire, m_if.fire_any, exp[i]);
      end
    end
    n_chk++;
    if (m_if.err_count !== 8'd3 || m_if.first_ch !== 2'd0 ||
        m_if.sticky_err !== 1'b1) begin
      n_fail++;
      $display("FAIL single_cnt got cnt=%0d fc=%0d st=%b want 3/0/1",
               m_if.err_count, m_if.first_ch, m_if.sticky_err);
    end
    n_chk++;
    if (m_if.cov_changes !== (COV ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL single_cov got %0d want %0d", m_if.cov_changes, COV ? 1 : 0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 16'h00F0, 0);
    drive(1, 16'h0010, 0);
    n_chk++;
    if (w_if.fire !== 4'b0000 || w_if.err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_mod got fire=%b cnt=%0d want 0000/0",
               w_if.fire, w_if.err_count);
    end
    n_chk++;
    if (m_if.fire !== 4'b0010 || m_if.err_count !== 8'd1 ||
        m_if.first_ch !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_abs got fire=%b cnt=%0d fc=%0d want 0010/1/1",
               m_if.fire, m_if.err_count, m_if.first_ch);
    end
    n_chk++;
    if (w_if.cov_changes !== (COV ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL wrap_cov got %0d want %0d", w_if.cov_changes, COV ? 1 : 0);
    end
  endtask

  task automatic test_enable();
    do_reset();
    drive(0, 16'h0000, 0);
    drive(0, 16'h0800, 0);
    n_chk++;
    if (m_if.fire !== 4'b0000) begin
      n_fail++;
      $display("FAIL en_off got %b want 0000", m_if.fire);
    end
    drive(1, 16'h0800, 0);
    drive(1, 16'h0A00, 0);
    n_chk++;
    if (m_if.fire !== 4'b0000 || m_if.err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL en_prime got fire=%b cnt=%0d want 0000/0",
               m_if.fire, m_if.err_count);
    end
    drive(0, 16'h0A00, 0);
    drive(1, 16'h0000, 0);
    n_chk++;
    if (m_if.fire !== 4'b0000) begin
      n_fail++;
      $display("FAIL en_reprime got %b want 0000", m_if.fire);
    end
    n_chk++;
    if (m_if.cov_changes !== (COV ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL en_cov got %0d want %0d", m_if.cov_changes, COV ? 1 : 0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1, 16'h0000, 0);
    drive(1, 16'h1010, 0);
    n_chk++;
    if (m_if.fire !== 4'b1010 || m_if.fire_any !== 1'b1 ||
        m_if.err_count !== 8'd2 || m_if.first_ch !== 2'd1) begin
      n_fail++;
      $display("FAIL simul got fire=%b any=%b cnt=%0d fc=%0d want 1010/1/2/1",
               m_if.fire, m_if.fire_any, m_if.err_count, m_if.first_ch);
    end
    drive(1, 16'h1080, 1);
    n_chk++;
    if (m_if.fire !== 4'b0010 || m_if.err_count !== 8'd0 ||
        m_if.sticky_err !== 1'b0 || m_if.first_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL clear got fire=%b cnt=%0d st=%b fc=%0d want 0010/0/0/0",
               m_if.fire, m_if.err_count, m_if.sticky_err, m_if.first_ch);
    end
    drive(1, 16'h1180, 0);
    drive(1, 16'h1181, 0);
    n_chk++;
    if (m_if.fire !== 4'b0001 || m_if.err_count !== 8'd2 ||
        m_if.first_ch !== 2'd2 || m_if.sticky_err !== 1'b1) begin
      n_fail++;
      $display("FAIL first_hold got fire=%b cnt=%0d fc=%0d st=%b want 0001/2/2/1",
               m_if.fire, m_if.err_count, m_if.first_ch, m_if.sticky_err);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 16'h0000, 0);
    for (int i = 0; i < 5; i++) drive(1, (i % 2 == 0) ? 16'h1 : 16'h0, 0);
    n_chk++;
    if (s_if.err_count !== 2'd3 || m_if.err_count !== 8'd5) begin
      n_fail++;
      $display("FAIL sat got small=%0d big=%0d want 3/5",
               s_if.err_count, m_if.err_count);
    end
    drive(1, 16'h3, 0);
    drive(1, 16'h7, 0);
    drive(1, 16'h9, 0);
    n_chk++;
    if (m_if.fire !== 4'b0000 || m_if.cov_changes !== (COV ? 8'd3 : 8'd0)) begin
      n_fail++;
      $display("FAIL cover got fire=%b cov=%0d want 0000/%0d",
               m_if.fire, m_if.cov_changes, COV ? 3 : 0);
    end
    drive(1, 16'hE, 0);
    n_chk++;
    if (m_if.fire !== 4'b0001 || m_if.err_count !== 8'd6) begin
      n_fail++;
      $display("FAIL max_edge got fire=%b cnt=%0d want 0001/6",
               m_if.fire, m_if.err_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 16'h0000, 0);
    drive(1, 16'h0001, 0);
    n_chk++;
    if (m_if.fire !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_pre got %b want 0001", m_if.fire);
    end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (m_if.fire !== 4'b0 || m_if.err_count !== 8'd0 ||
        m_if.sticky_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got fire=%b cnt=%0d st=%b want 0000/0/0",
               m_if.fire, m_if.err_count, m_if.sticky_err);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    drive(1, 16'h0009, 0);
    n_chk++;
    if (m_if.fire !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_idle got %b want 0000", m_if.fire);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_enable();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
